// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
//   data_out        received byte, stable while data_out_valid is high
//   data_out_valid  a byte is available
//   data_out_ready  consumer accepts; transfer on a clk edge when valid && ready
// master: the receiver (drives byte and valid). slave: the consumer (drives ready).
interface uart_rx_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, counterpart of uart_tx.
// The asynchronous rx line passes through a 2-flop synchroniser. Each bit is sampled
// once at its centre, and the bits are assembled LSB first. Completed bytes go to the
// core over a valid/ready handshake.
// Optional build macro UART_RX_FIFO_EN: replaces the single holding register with a
// FIFO_DEPTH-entry FIFO.
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   rx         serial input, idles high, asynchronous to clk
//   bus        uart_rx_if.master: data_out / data_out_valid / data_out_ready
//   frame_err  one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun    one-cycle pulse, completed byte dropped because no storage is free
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit, >= 8
//   FIFO_DEPTH    FIFO entries, power of 2 >= 2 (only used with UART_RX_FIFO_EN)
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx,
    uart_rx_if.master bus,
    output logic     frame_err,
    output logic     overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    // Elaboration-time parameter sanity checks
    if (CLKS_PER_BIT < 8) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be >= 8");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of 2 >= 2");
    end

    logic             rx_meta;
    logic             rxs;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shift;
    logic [7:0]       shift_nxt;
    logic             commit_c;
    logic             ferr_c;
    logic             ovr_c;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            frame_err <= ferr_c;
            overrun   <= ovr_c;
        end
    end

    // Next-state logic: sample at mid start bit, then every bit period at bit centres
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        commit_c    = 1'b0;
        ferr_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    if (!rxs) begin
                        state_nxt   = S_DATA;
                        cnt_nxt     = '0;
                        bit_idx_nxt = '0;
                    end else begin
                        // Start bit vanished before its centre: treat as a glitch
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rxs, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        commit_c  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_c    = 1'b1;
                        state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) must not be taken as a new start bit
                if (rxs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty_c;
    logic          full_c;
    logic          pop_c;
    logic          push_c;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_c   = !empty_c && bus.data_out_ready;
    // A pop in the same cycle frees a slot, so a commit while full still fits
    assign push_c  = commit_c && (!full_c || pop_c);
    assign ovr_c   = commit_c && full_c && !pop_c;

    // Receive FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    assign bus.data_out       = mem[rd_ptr[AW-1:0]];
    assign bus.data_out_valid = !empty_c;
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;

    // Only a byte still unaccepted this cycle blocks the new one
    assign ovr_c = commit_c && hold_vld_q && !bus.data_out_ready;

    // Single holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (commit_c && !ovr_c) begin
            hold_q     <= shift;
            hold_vld_q <= 1'b1;
        end else if (hold_vld_q && bus.data_out_ready) begin
            hold_vld_q <= 1'b0;
        end
    end

    assign bus.data_out       = hold_q;
    assign bus.data_out_valid = hold_vld_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=16). A transaction-level model
// schedules each frame's commit at a fixed latency after its start edge. The
// commit goes into a queue of capacity 1, or FIFO_DEPTH with UART_RX_FIFO_EN.
// The model is compared against the DUT every cycle. Directed literal checks
// pin the latency and the delivered byte values.
module tb_uart_rx;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
    // Commit edge relative to the last clk edge before the rx falling edge
    localparam int unsigned LAT   = 3 + CPB / 2 + 9 * CPB;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned CAP   = DEPTH;
`else
    localparam int unsigned CAP   = 1;
`endif

    typedef struct {
        int unsigned at;
        logic [7:0]  b;
        logic        good;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic frame_err;
    logic overrun;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .bus       (bus),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    ev_t         evq[$];
    logic [7:0]  mq[$];
    logic [7:0]  acc_log[$];
    logic        exp_ferr = 1'b0;
    logic        exp_ovr  = 1'b0;
    logic        m_pop;
    logic        m_com;
    ev_t         m_ev;
    bit          t6_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction model: storage of capacity CAP, pop before push on each edge
    always @(posedge clk) begin
        cyc      = cyc + 1;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (!rst_n) begin
            evq.delete();
            mq.delete();
        end else begin
            m_pop = (mq.size() > 0) && bus.data_out_ready;
            m_com = (evq.size() > 0) && (evq[0].at == cyc);
            if (m_com) m_ev = evq.pop_front();
            if (m_pop) begin
                acc_log.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (m_com) begin
                if (!m_ev.good)                     exp_ferr = 1'b1;
                else if (mq.size() < int'(CAP))     mq.push_back(m_ev.b);
                else                                exp_ovr  = 1'b1;
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 32'(bus.data_out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) chk("data_out", 32'(bus.data_out), 32'(mq[0]));
            chk("frame_err", 32'(frame_err), 32'(exp_ferr));
            chk("overrun", 32'(overrun), 32'(exp_ovr));
        end
    end

    // Drive one 8N1 frame; call at posedge+1, returns at posedge+1 after the stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop);
        evq.push_back('{at: cyc + LAT, b: b, good: stop});
        rx = 1'b0;
        repeat (CPB) @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(posedge clk); #1;
        end
        rx = stop;
        repeat (CPB) @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"},  32'(bus.data_out), 32'h0);
        chk({tag, "_valid"}, 32'(bus.data_out_valid), 32'h0);
        chk({tag, "_ferr"},  32'(frame_err), 32'h0);
        chk({tag, "_ovr"},   32'(overrun), 32'h0);
    endtask

    initial begin
        int n0;
        bus.data_out_ready = 1'b1;
        idle(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        idle(5);

        // 1: 0x55 with ready=1, valid for exactly one cycle at edge +155
        fork
            send_frame(8'h55, 1'b1);
            begin
                idle(LAT - 1);
                chk("t1_valid_early", 32'(bus.data_out_valid), 32'h0);
                idle(1);
                chk("t1_valid", 32'(bus.data_out_valid), 32'h1);
                chk("t1_data", 32'(bus.data_out), 32'h55);
                chk("t1_ferr", 32'(frame_err), 32'h0);
                idle(1);
                chk("t1_valid_gone", 32'(bus.data_out_valid), 32'h0);
            end
        join
        idle(10);

        // 2: short low glitch is ignored, next frame received
        n0 = acc_log.size();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        chk("t2_glitch_nothing", 32'(acc_log.size() - n0), 32'h0);
        send_frame(8'hA3, 1'b1);
        idle(10);
        chk("t2_count", 32'(acc_log.size() - n0), 32'h1);
        chk("t2_byte", 32'(acc_log[n0]), 32'hA3);

        // 3: bad stop bit, then line held low, then a good frame
        n0 = acc_log.size();
        fork
            send_frame(8'h3C, 1'b0);
            begin
                idle(LAT);
                chk("t3_ferr", 32'(frame_err), 32'h1);
                chk("t3_valid", 32'(bus.data_out_valid), 32'h0);
                idle(1);
                chk("t3_ferr_pulse", 32'(frame_err), 32'h0);
            end
        join
        idle(40);
        rx = 1'b1;
        idle(20);
        chk("t3_nothing", 32'(acc_log.size() - n0), 32'h0);
        send_frame(8'h7E, 1'b1);
        idle(10);
        chk("t3_count", 32'(acc_log.size() - n0), 32'h1);
        chk("t3_byte", 32'(acc_log[n0]), 32'h7E);

        // 4: consumer stalled
        n0 = acc_log.size();
        bus.data_out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
`ifdef UART_RX_FIFO_EN
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h55, 1'b1);
`endif
        idle(20);
        chk("t4_hold_valid", 32'(bus.data_out_valid), 32'h1);
        chk("t4_hold_data", 32'(bus.data_out), 32'h11);
        bus.data_out_ready = 1'b1;
        idle(10);
`ifdef UART_RX_FIFO_EN
        chk("t4_count", 32'(acc_log.size() - n0), 32'h4);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] want;
            want = 8'(8'h11 * (i + 1));
            chk("t4_order", 32'(acc_log[n0 + i]), 32'(want));
        end
`else
        chk("t4_count", 32'(acc_log.size() - n0), 32'h1);
        chk("t4_byte", 32'(acc_log[n0]), 32'h11);
`endif

        // 5: reset during data bit 3 with a byte stored
        bus.data_out_ready = 1'b0;
        send_frame(8'h99, 1'b1);
        idle(5);
        chk("t5_stored", 32'(bus.data_out_valid), 32'h1);
        rx = 1'b0;
        idle(CPB);
        for (int k = 0; k < 3; k++) begin
            rx = k[0];
            idle(CPB);
        end
        rx = 1'b1;
        idle(CPB / 2);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("t5_async");
        idle(3);
        rst_n = 1'b1;
        bus.data_out_ready = 1'b1;
        idle(20);
        n0 = acc_log.size();
        send_frame(8'hC9, 1'b1);
        idle(10);
        chk("t5_count", 32'(acc_log.size() - n0), 32'h1);
        chk("t5_byte", 32'(acc_log[n0]), 32'hC9);

        // 6: eight back-to-back frames with ready toggling every 7 cycles
        n0 = acc_log.size();
        t6_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
                t6_done = 1'b1;
            end
            begin
                while (!t6_done) begin
                    idle(7);
                    bus.data_out_ready = ~bus.data_out_ready;
                end
            end
        join
        bus.data_out_ready = 1'b1;
        idle(20);
        chk("t6_count", 32'(acc_log.size() - n0), 32'h8);
        for (int i = 0; i < 8; i++) begin
            chk("t6_order", 32'(acc_log[n0 + i]), 32'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
